// File: rtl/serial_bcd_add_ctrl.sv
// Digit-serial BCD adder: one shared single-digit BCD adder walks the operands
// from digit 0 upward, one digit per clock, under a three-state controller.
module serial_bcd_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] Addend,
    input  logic [4*DIGITS-1:0] Augend,
    input  logic                Carry_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] Sum,
    output logic                Carry_out,
    output logic                Err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [3:0] a_dig, b_dig, dsum;
    logic [4:0] t;
    logic       dcarry, dinv;

    // The single time-shared digit adder; invalid digits are added unsaturated.
    always_comb begin
        a_dig  = a_q[idx_q*4 +: 4];
        b_dig  = b_q[idx_q*4 +: 4];
        t      = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        dinv   = (a_dig > 4'd9) || (b_dig > 4'd9);
        dcarry = (t > 5'd9);
        dsum   = dcarry ? (t[3:0] + 4'd6) : t[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = Addend;
                    b_d     = Augend;
                    carry_d = Carry_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*4 +: 4] = dsum;
                carry_d = dcarry;
                err_d   = err_q | dinv;
                if (idx_q == LAST) begin
                    cout_d  = dcarry;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Operand holding registers carry no reset; they are reloaded on every start.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy      = (state_q == ADD);
    assign done      = (state_q == DONE);
    assign Sum       = sum_q;
    assign Carry_out = cout_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_serial_bcd_add_ctrl.sv
// Directed-vector bench for serial_bcd_add_ctrl with DIGITS=4.
module tb_serial_bcd_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] Addend = '0;
    logic [15:0] Augend = '0;
    logic        Carry_in = 1'b0;
    logic        busy, done, Carry_out, Err;
    logic [15:0] Sum;

    int vectors = 0;
    int miscompares = 0;

    serial_bcd_add_ctrl #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Addend    (Addend),
        .Augend    (Augend),
        .Carry_in  (Carry_in),
        .busy      (busy),
        .done      (done),
        .Sum       (Sum),
        .Carry_out (Carry_out),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation; rel releases reset together with start, poke pulses start mid-ADD.
    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] es, input logic eco,
                      input logic eerr, input bit rel, input bit poke);
        int ndone;
        int lat;
        @(negedge clk);
        Addend = a; Augend = b; Carry_in = cin; start = 1'b1;
        if (rel) rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Addend = 16'hFFFF; Augend = 16'hFFFF; Carry_in = 1'b1;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        ndone = 0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            if (poke && i == 2) begin
                start = 1'b1; Addend = 16'h1111; Augend = 16'h2222; Carry_in = 1'b0;
            end
            if (poke && i == 3) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat == 0) lat = i;
            end
        end
        chk({tag, ".latency"}, lat, 32'd4);
        chk({tag, ".ndone"}, ndone, 32'd1);
        chk({tag, ".sum"}, {16'd0, Sum}, {16'd0, es});
        chk({tag, ".cout"}, {31'd0, Carry_out}, {31'd0, eco});
        chk({tag, ".err"}, {31'd0, Err}, {31'd0, eerr});
    endtask

    initial begin
        int nd;
        #12;
        chk("rst.sum", {16'd0, Sum}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.cout", {31'd0, Carry_out}, 32'd0);
        chk("rst.err", {31'd0, Err}, 32'd0);

        op("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, 1'b0);
        op("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        op("cinonly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        op("max",     16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0);
        op("invalid", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
        op("alt",     16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
        op("busyign", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort an operation after two processed digits.
        @(negedge clk);
        Addend = 16'h1234; Augend = 16'h5678; Carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.sum", {16'd0, Sum}, 32'd0);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.cout", {31'd0, Carry_out}, 32'd0);
        chk("abort.err", {31'd0, Err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort.nodone", nd, 32'd0);
        op("after", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_bcd_add_ctrl.md
SERIAL_BCD_ADD_CTRL -- requirements
Module: serial_bcd_add_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: the operation request, sampled only in IDLE.
REQ-005 The block SHALL have port Addend, input, 4*DIGITS bits: the first BCD operand; digit 0 is in bits [3:0].
REQ-006 The block SHALL have port Augend, input, 4*DIGITS bits: the second BCD operand, with the same packing as Addend.
REQ-007 The block SHALL have port Carry_in, input, 1 bit: the carry into digit 0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while digits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port Sum, output, 4*DIGITS bits: the BCD result.
REQ-011 The block SHALL have port Carry_out, output, 1 bit: the decimal carry out of the top digit.
REQ-012 The block SHALL have port Err, output, 1 bit: high if any operand digit processed was greater than 9.

Function
REQ-013 The block SHALL contain exactly one single-digit BCD adder, time-shared across digits, with one digit processed per clock.
REQ-014 The digit rule SHALL be: t = a + b + c computed at 5-bit width; if t > 9 then digit sum = (t + 6) mod 16 and digit carry = 1; otherwise digit sum = t and digit carry = 0.
REQ-015 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-016 In IDLE with start = 1 at edge k, the block SHALL latch Addend, Augend and Carry_in; clear the digit index, Sum and Err; and go to ADD.
REQ-017 In ADD, each edge SHALL process the digit at the current index using the registered carry, write that Sum digit, update the carry register, OR the invalid-digit flag into Err, and increment the index.
REQ-018 On the edge that processes digit DIGITS-1 (edge k+DIGITS), the block SHALL load Carry_out with the final carry and go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-020 busy SHALL equal (state == ADD); the latency from the start edge to done high SHALL be DIGITS cycles.
REQ-021 start SHALL be ignored in ADD and DONE, with no latch, no restart and no queuing.
REQ-022 Input changes after the start edge SHALL NOT affect the operation in flight.
REQ-023 Sum, Carry_out and Err SHALL hold their values from the end of an operation until the next accepted start.
REQ-024 An invalid digit (greater than 9) SHALL still be added per REQ-014 with no saturation, and SHALL set Err.
REQ-025 The digit index SHALL be wide enough for DIGITS-1 and SHALL NOT wrap while in ADD.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, Sum 0, Carry_out 0, Err 0, and the internal carry and index to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation; after rst_n rises, no done SHALL occur until a new start is accepted.
REQ-028 A start that is high on the first edge after rst_n rises SHALL be accepted normally.

Verification
REQ-029 Basic add (DIGITS=4): Addend=0x1234, Augend=0x5678, Carry_in=0 -> done 4 cycles after the start edge, Sum=0x6912, Carry_out=0, Err=0.
REQ-030 Full carry ripple: 0x9999 + 0x0001, Carry_in=0 -> Sum=0x0000, Carry_out=1, Err=0.
REQ-031 Carry-in only: 0x0000 + 0x0000, Carry_in=1 -> Sum=0x0001, Carry_out=0; then 0x9999 + 0x9999, Carry_in=1 -> Sum=0x9999, Carry_out=1.
REQ-032 Busy behaviour: start pulsed during ADD with different operands -> the original result completes unchanged, with exactly one done pulse.
REQ-033 Invalid digit: Addend=0x000A, Augend=0x0000 -> Err=1, Sum=0x0010, Carry_out=0.
REQ-034 Reset mid-operation: rst_n pulsed low after 2 ADD cycles -> all outputs 0 immediately, no done pulse, and the next operation is correct.
